// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mul_state_e        : control FSM states (IDLE, RUN, DONE)
//   MUL_WIDTH_DEFAULT  : default operand width in bits
package mul_pkg;

    localparam int MUL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-add datapath for the sequential multiplier.
// Processes the multiplier MSB-first: each step doubles the accumulator and
// adds the multiplicand magnitude when the current multiplier bit is set.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture operand magnitudes and sign, clear accumulator
//   step              : perform one shift-add iteration
//   finish            : last iteration; load (optionally negated) sum into result
//   sgn               : operands are two's complement
//   multiplicand      : WIDTH-bit multiplicand
//   multiplier        : WIDTH-bit multiplier
//   result            : 2*WIDTH-bit registered product
module shift_add_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] result
);

    logic [WIDTH-1:0]   mcand_mag;
    logic [WIDTH-1:0]   mplier_sh;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;

    // Carry-out of the 2*WIDTH adder is dropped; the magnitude product
    // never exceeds 2^(2*WIDTH-2) in signed mode, so nothing is lost.
    assign addend = mplier_sh[WIDTH-1] ? {{WIDTH{1'b0}}, mcand_mag} : '0;
    assign sum    = (acc << 1) + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_mag <= '0;
            mplier_sh <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            result    <= '0;
        end else if (load) begin
            // Negating -2^(WIDTH-1) wraps back to 100..0, which read as
            // unsigned is exactly its magnitude.
            mcand_mag <= (sgn && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
            mplier_sh <= (sgn && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
            neg       <= sgn && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc       <= '0;
        end else if (step) begin
            acc       <= sum;
            mplier_sh <= mplier_sh << 1;
            // -0 == 0, so a zero product never comes out as negative zero.
            if (finish)
                result <= neg ? -sum : sum;
        end
    end

endmodule

// File: rtl/param_seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, signed or unsigned per operation.
// Fixed latency: accept on edge 0, WIDTH shift-add edges, done_o high for
// the one cycle after edge WIDTH, then back to IDLE.
// Ports:
//   mul_clk_i      : clock
//   mul_nreset_i   : asynchronous active-low reset
//   start_i        : start request, honoured only while ready_o
//   signed_i       : 1 = two's-complement operands
//   multiplicand_i : multiplicand, sampled on the accepting edge
//   multiplier_i   : multiplier, sampled on the accepting edge
//   ready_o        : idle, can accept start_i
//   busy_o         : operation in progress (RUN or DONE)
//   done_o         : one-cycle pulse, mul_result_o holds a new product
//   mul_result_o   : registered 2*WIDTH-bit product
module param_seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               mul_clk_i,
    input  logic               mul_nreset_i,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] mul_result_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             load, step, finish;

    always_ff @(posedge mul_clk_i or negedge mul_nreset_i) begin
        if (!mul_nreset_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                cnt <= CNT_W'(WIDTH);
            else if (step)
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        ready_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        unique case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                step   = 1'b1;
                // cnt == 1 marks the WIDTH-th iteration.
                if (cnt == CNT_W'(1)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    shift_add_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk          (mul_clk_i),
        .rst_n        (mul_nreset_i),
        .load         (load),
        .step         (step),
        .finish       (finish),
        .sgn          (signed_i),
        .multiplicand (multiplicand_i),
        .multiplier   (multiplier_i),
        .result       (mul_result_o)
    );

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Bench for param_seq_multiplier: four instances (WIDTH 8, 5, 2, 16) share
// clock, reset and operand buses; sel chooses which one sees start.
// Expected products are queued at accept and checked when done_o pulses.
module tb_param_seq_multiplier;

    localparam int WV[4] = '{8, 5, 2, 16};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    int          sel = 0;

    logic [3:0]  rdy, bsy, dn;
    logic [15:0] r8;
    logic [9:0]  r5;
    logic [3:0]  r2;
    logic [31:0] r16;
    logic [63:0] res  [4];
    logic [63:0] prev [4];
    logic [63:0] exp_q[$];
    logic [63:0] e_mon;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    param_seq_multiplier #(.WIDTH(8)) u_w8 (
        .mul_clk_i(clk), .mul_nreset_i(rst_n), .start_i(start && sel == 0), .signed_i(sgn),
        .multiplicand_i(a[7:0]), .multiplier_i(b[7:0]),
        .ready_o(rdy[0]), .busy_o(bsy[0]), .done_o(dn[0]), .mul_result_o(r8));
    param_seq_multiplier #(.WIDTH(5)) u_w5 (
        .mul_clk_i(clk), .mul_nreset_i(rst_n), .start_i(start && sel == 1), .signed_i(sgn),
        .multiplicand_i(a[4:0]), .multiplier_i(b[4:0]),
        .ready_o(rdy[1]), .busy_o(bsy[1]), .done_o(dn[1]), .mul_result_o(r5));
    param_seq_multiplier #(.WIDTH(2)) u_w2 (
        .mul_clk_i(clk), .mul_nreset_i(rst_n), .start_i(start && sel == 2), .signed_i(sgn),
        .multiplicand_i(a[1:0]), .multiplier_i(b[1:0]),
        .ready_o(rdy[2]), .busy_o(bsy[2]), .done_o(dn[2]), .mul_result_o(r2));
    param_seq_multiplier #(.WIDTH(16)) u_w16 (
        .mul_clk_i(clk), .mul_nreset_i(rst_n), .start_i(start && sel == 3), .signed_i(sgn),
        .multiplicand_i(a[15:0]), .multiplier_i(b[15:0]),
        .ready_o(rdy[3]), .busy_o(bsy[3]), .done_o(dn[3]), .mul_result_o(r16));

    assign res[0] = 64'(r8);
    assign res[1] = 64'(r5);
    assign res[2] = 64'(r2);
    assign res[3] = 64'(r16);

    // Scoreboard: pop on every done pulse; outside done the result must hold.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_n) begin
                if (dn[k]) begin
                    checks++;
                    if (k != sel || exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_done inst=%0d got=%h", k, res[k]);
                    end else begin
                        e_mon = exp_q.pop_front();
                        if (res[k] !== e_mon) begin
                            fails++;
                            $display("FAIL product inst=%0d got=%h exp=%h", k, res[k], e_mon);
                        end
                    end
                end else if (res[k] !== prev[k]) begin
                    checks++;
                    fails++;
                    $display("FAIL result_stable inst=%0d got=%h exp=%h", k, res[k], prev[k]);
                end
            end
            prev[k] <= res[k];
        end
    end

    function automatic logic [63:0] ref_mul(int w, bit s, logic [31:0] x, logic [31:0] y);
        logic [63:0] msk;
        longint      xa, ya;
        msk = (64'd1 << w) - 64'd1;
        xa  = longint'({32'd0, x} & msk);
        ya  = longint'({32'd0, y} & msk);
        if (s && xa[w-1]) xa = xa - (longint'(1) << w);
        if (s && ya[w-1]) ya = ya - (longint'(1) << w);
        return 64'(xa * ya) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic wait_done(int k, output int lat);
        lat = 0;
        while (!dn[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // One operation on instance k, starting in the current IDLE cycle.
    task automatic run_op(int k, bit s, logic [31:0] x, logic [31:0] y, logic [63:0] e);
        int lat;
        @(negedge clk);
        checks++;
        if (rdy[k] !== 1'b1) begin
            fails++;
            $display("FAIL ready_before_start inst=%0d got=%b exp=1", k, rdy[k]);
        end
        sel = k; sgn = s; a = x; b = y; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; sgn = 1'($urandom);
        checks++;
        if (bsy[k] !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_accept inst=%0d got=%b exp=1", k, bsy[k]);
        end
        wait_done(k, lat);
        checks++;
        if (lat != WV[k]) begin
            fails++;
            $display("FAIL latency inst=%0d got=%0d exp=%0d", k, lat, WV[k]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dn[k] !== 1'b0 || rdy[k] !== 1'b1 || bsy[k] !== 1'b0) begin
            fails++;
            $display("FAIL done_one_cycle inst=%0d done=%b ready=%b busy=%b exp=0/1/0",
                     k, dn[k], rdy[k], bsy[k]);
        end
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdy[k] !== 1'b1 || bsy[k] !== 1'b0 || dn[k] !== 1'b0 || res[k] !== 64'd0) begin
                fails++;
                $display("FAIL reset_state inst=%0d ready=%b busy=%b done=%b res=%h exp=1/0/0/0",
                         k, rdy[k], bsy[k], dn[k], res[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_w8_fixed();
        run_op(0, 1'b0, 32'd255, 32'd255, 64'hFE01);
        run_op(0, 1'b1, 32'h80,  32'h80,  64'h4000);
        run_op(0, 1'b1, 32'hFD,  32'h05,  64'hFFF1);
        run_op(0, 1'b1, 32'h7F,  32'hFF,  64'hFF81);
        run_op(0, 1'b1, 32'h00,  32'h9C,  64'h0000);
    endtask

    task automatic test_w5_fixed();
        run_op(1, 1'b0, 32'd31, 32'd31, 64'h3C1);
        run_op(1, 1'b0, 32'd0,  32'd17, 64'h0);
    endtask

    task automatic test_start_held();
        int lat;
        @(negedge clk);
        sel = 0; sgn = 1'b0; a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(64'd63);
        lat = 0;
        while (!dn[0] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (!dn[0]) begin a = $urandom; b = $urandom; sgn = 1'($urandom); end
        end
        checks++;
        if (lat != 8) begin
            fails++;
            $display("FAIL held_latency got=%0d exp=8", lat);
        end
        a = 32'd11; b = 32'd13; sgn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            fails++;
            $display("FAIL held_no_accept_in_done ready=%b busy=%b exp=1/0", rdy[0], bsy[0]);
        end
        @(posedge clk);
        exp_q.push_back(64'd143);
        #1;
        start = 1'b0;
        checks++;
        if (bsy[0] !== 1'b1) begin
            fails++;
            $display("FAIL held_accept_in_idle busy=%b exp=1", bsy[0]);
        end
        wait_done(0, lat);
        checks++;
        if (lat != 8) begin
            fails++;
            $display("FAIL held_second_latency got=%0d exp=8", lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        sel = 0; sgn = 1'b0; a = 32'd50; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || dn[0] !== 1'b0 || res[0] !== 64'd0) begin
            fails++;
            $display("FAIL reset_mid_op ready=%b busy=%b done=%b res=%h exp=1/0/0/0",
                     rdy[0], bsy[0], dn[0], res[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 1'b1, 32'hF6, 32'h0C, 64'hFF88);
    endtask

    task automatic test_back_to_back();
        int          ks[3] = '{2, 0, 3};
        int          k;
        bit          s;
        logic [31:0] x, y;
        for (int j = 0; j < 3; j++) begin
            k = ks[j];
            for (int i = 0; i < 20; i++) begin
                s = 1'($urandom);
                x = $urandom;
                y = $urandom;
                if (i < 2) begin
                    x = 32'd1 << (WV[k] - 1);
                    y = x;
                    s = (i == 0);
                end
                run_op(k, s, x, y, ref_mul(WV[k], s, x, y));
            end
        end
    endtask

    initial begin
        test_reset();
        test_w8_fixed();
        test_w5_fixed();
        test_start_held();
        test_reset_mid_op();
        test_back_to_back();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
